// File: rtl/fft_twid_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_twid_pkg
// Brief    : Shared constants, types and the quarter-wave sine generator for
//            the FFT twiddle-table initialiser.
// Revision : 1.0 - initial release
// ============================================================================
package fft_twid_pkg;

    localparam int DEPTH     = 64;          // twiddle entries (power of two, >= 8)
    localparam int LOG_DEPTH = 6;           // log2(DEPTH), RAM address width
    localparam int TW_W      = 32;          // signed width of re / im
    localparam int Q         = DEPTH / 2;   // quarter-wave ROM spans 0..Q

    localparam real c_pi = 3.14159265358979323846;

    typedef logic signed [TW_W-1:0] twComp_t;

    // RAM word layout: imaginary part in the upper half.
    typedef struct packed {
        twComp_t im;
        twComp_t re;
    } twWord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } twState_t;

    // round(sin(pi*idx/(2Q)) * (2^(TW_W-1)-1)), evaluated at elaboration.
    // A Taylor series keeps this independent of tool math libraries; on
    // [0, pi/2] twelve terms are far below one LSB of a 32-bit result.
    function automatic twComp_t quarterSine(input int idx);
        real    angle;
        real    term;
        real    acc;
        real    amp;
        integer rounded;
        angle = c_pi * real'(idx) / real'(2 * Q);
        term  = angle;
        acc   = angle;
        for (int n = 1; n <= 12; n++) begin
            term = -term * angle * angle / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = 1.0;
        for (int b = 0; b < TW_W - 1; b++) begin
            amp = amp * 2.0;
        end
        amp     = amp - 1.0;
        // Argument is never negative, so truncating x+0.5 rounds to nearest.
        rounded = $rtoi(acc * amp + 0.5);
        return twComp_t'(rounded);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_twid_qrom.sv
`default_nettype none
// ============================================================================
// Module   : fft_twid_qrom
// Brief    : Quarter-wave sine table (Q+1 entries) with two synchronous read
//            ports and a one-cycle registered output.
// Revision : 1.0 - initial release
// ============================================================================
module fft_twid_qrom
    import fft_twid_pkg::*;
(
    input  logic                 clk,
    input  logic                 nGrst,
    input  logic [LOG_DEPTH-1:0] i_sinAddr,
    input  logic [LOG_DEPTH-1:0] i_cosAddr,
    output twComp_t              o_sinData,
    output twComp_t              o_cosData
);

    // Table is padded to the full address space so every index is defined;
    // addresses above Q are never issued by the mapper.
    localparam int c_rows = 1 << LOG_DEPTH;

    twComp_t w_table [c_rows];
    twComp_t r_sinData;
    twComp_t r_cosData;

    for (genvar gi = 0; gi < c_rows; gi++) begin : g_row
        if (gi <= Q) begin : g_sine
            localparam twComp_t c_entry = quarterSine(gi);
            assign w_table[gi] = c_entry;
        end else begin : g_pad
            assign w_table[gi] = '0;
        end
    end

    // Register both read ports so the table looks like a synchronous ROM.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_sinData <= '0;
            r_cosData <= '0;
        end else begin
            r_sinData <= w_table[i_sinAddr];
            r_cosData <= w_table[i_cosAddr];
        end
    end

    assign o_sinData = r_sinData;
    assign o_cosData = r_cosData;

endmodule
`default_nettype wire

// File: rtl/fft_twid_init.sv
`default_nettype none
// ============================================================================
// Module   : fft_twid_init
// Brief    : Fills the FFT twiddle RAM with W_2N^k = cos(pi*k/DEPTH) -
//            j*sin(pi*k/DEPTH), k = 0..DEPTH-1, one word per clock, using a
//            quarter-wave sine ROM and symmetry. Three-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module fft_twid_init
    import fft_twid_pkg::*;
(
    input  logic                 clk,
    input  logic                 nGrst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [LOG_DEPTH-1:0] wAddr,
    output logic [2*TW_W-1:0]    wD,
    output logic                 wEn
);

    localparam logic [LOG_DEPTH-1:0] c_zero  = '0;
    localparam logic [LOG_DEPTH-1:0] c_one   = LOG_DEPTH'(1);
    localparam logic [LOG_DEPTH-1:0] c_q     = LOG_DEPTH'(Q);
    localparam logic [LOG_DEPTH-1:0] c_lastK = LOG_DEPTH'(DEPTH - 1);

    twState_t               r_state;
    twState_t               w_nextState;
    logic                   w_issue;
    logic                   w_load;
    logic [LOG_DEPTH-1:0]   r_k;

    logic [LOG_DEPTH-1:0]   w_sinIdx;
    logic [LOG_DEPTH-1:0]   w_cosIdx;
    logic                   w_negCos;

    logic                   r_s1Valid;
    logic [LOG_DEPTH-1:0]   r_s1K;
    logic [LOG_DEPTH-1:0]   r_s1SinIdx;
    logic [LOG_DEPTH-1:0]   r_s1CosIdx;
    logic                   r_s1NegCos;

    logic                   r_s2Valid;
    logic [LOG_DEPTH-1:0]   r_s2K;
    logic                   r_s2NegCos;
    twComp_t                w_sinData;
    twComp_t                w_cosData;

    twWord_t                w_word;
    logic                   r_wEn;
    logic [LOG_DEPTH-1:0]   r_wAddr;
    twWord_t                r_wD;

    // FSM state register.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and status outputs; start is only honoured in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_load      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_nextState = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                w_issue = 1'b1;
                if (r_k == c_lastK) begin
                    w_nextState = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                // Earlier stages empty and the final write on the port now.
                if (!r_s1Valid && !r_s2Valid && r_wEn) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Index counter: cleared on a fresh start, stops at the last index.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_k <= '0;
        end else if (w_load) begin
            r_k <= '0;
        end else if (w_issue && (r_k != c_lastK)) begin
            r_k <= r_k + c_one;
        end
    end

    // Symmetry mapping; modular LOG_DEPTH-bit arithmetic yields DEPTH-k.
    always_comb begin
        w_sinIdx = r_k;
        w_cosIdx = c_q - r_k;
        w_negCos = 1'b0;
        if (r_k > c_q) begin
            w_sinIdx = c_zero - r_k;
            w_cosIdx = r_k - c_q;
            w_negCos = 1'b1;
        end
    end

    // Stage 1: capture the index and its ROM addresses.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_s1Valid  <= 1'b0;
            r_s1K      <= '0;
            r_s1SinIdx <= '0;
            r_s1CosIdx <= '0;
            r_s1NegCos <= 1'b0;
        end else begin
            r_s1Valid <= w_issue;
            if (w_issue) begin
                r_s1K      <= r_k;
                r_s1SinIdx <= w_sinIdx;
                r_s1CosIdx <= w_cosIdx;
                r_s1NegCos <= w_negCos;
            end
        end
    end

    fft_twid_qrom u_qrom (
        .clk       (clk),
        .nGrst     (nGrst),
        .i_sinAddr (r_s1SinIdx),
        .i_cosAddr (r_s1CosIdx),
        .o_sinData (w_sinData),
        .o_cosData (w_cosData)
    );

    // Stage 2: carry control alongside the registered ROM words.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_s2Valid  <= 1'b0;
            r_s2K      <= '0;
            r_s2NegCos <= 1'b0;
        end else begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2K      <= r_s1K;
                r_s2NegCos <= r_s1NegCos;
            end
        end
    end

    // Negations cannot overflow: ROM magnitudes never reach -2^(TW_W-1).
    always_comb begin
        w_word.im = -w_sinData;
        w_word.re = r_s2NegCos ? -w_cosData : w_cosData;
    end

    // Stage 3: RAM write port; address and data hold while wEn is low.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_wEn   <= 1'b0;
            r_wAddr <= '0;
            r_wD    <= '0;
        end else begin
            r_wEn <= r_s2Valid;
            if (r_s2Valid) begin
                r_wAddr <= r_s2K;
                r_wD    <= w_word;
            end
        end
    end

    assign wEn   = r_wEn;
    assign wAddr = r_wAddr;
    assign wD    = r_wD;

endmodule
`default_nettype wire

// File: tb/tb_fft_twid_init.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_twid_init
// Brief    : Self-checking bench for fft_twid_init against a real-valued
//            twiddle model with randomized start re-pulses and reset aborts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_twid_init;

    localparam int  c_n    = 64;
    localparam real c_pi   = 3.14159265358979323846;
    localparam real c_amp  = 2147483647.0;
    localparam logic [63:0] c_keyWord [4] = '{
        64'h00000000_7FFFFFFF,
        64'hA57D8667_5A827999,
        64'h80000001_00000000,
        64'hA57D8667_A57D8667
    };

    logic        clk = 1'b0;
    logic        nGrst;
    logic        start;
    logic        busy;
    logic        done;
    logic [5:0]  wAddr;
    logic [63:0] wD;
    logic        wEn;

    int cycleCnt = 0;
    int nChecks  = 0;
    int nFails   = 0;

    typedef struct {
        int          cyc;
        int          addr;
        logic [63:0] data;
        logic        busy;
    } wrRec_t;

    wrRec_t wrQ[$];
    int     doneCyc[$];
    logic   doneBusy[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    fft_twid_init dut (
        .clk   (clk),
        .nGrst (nGrst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .wAddr (wAddr),
        .wD    (wD),
        .wEn   (wEn)
    );

    // Log every RAM write and every done pulse, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        wrRec_t rec;
        if (wEn === 1'b1) begin
            rec.cyc  = cycleCnt;
            rec.addr = int'(wAddr);
            rec.data = wD;
            rec.busy = busy;
            wrQ.push_back(rec);
        end
        if (done === 1'b1) begin
            doneCyc.push_back(cycleCnt);
            doneBusy.push_back(busy);
        end
    end

    task automatic checkVal(input string tag, input longint obs, input longint exp,
                            input longint tol = 0);
        longint diff;
        nChecks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if ((tol == 0) ? (obs != exp) : (diff > tol)) begin
            nFails++;
            $display("FAIL %s: observed=0x%0h (%0d) expected=0x%0h (%0d) tol=%0d",
                     tag, obs, obs, exp, exp, tol);
        end
    endtask

    function automatic longint roundReal(input real x);
        if (x >= 0.0) return longint'($rtoi(x + 0.5));
        return -longint'($rtoi(0.5 - x));
    endfunction

    function automatic longint modelRe(input int k);
        return roundReal($cos(c_pi * real'(k) / real'(c_n)) * c_amp);
    endfunction

    function automatic longint modelIm(input int k);
        return roundReal(-$sin(c_pi * real'(k) / real'(c_n)) * c_amp);
    endfunction

    // Check one fill: start raised in cycle sc, logs examined from wb / db.
    task automatic verifyFill(input int sc, input int wb, input int db);
        int     nWr;
        int     nDn;
        wrRec_t r;
        longint re;
        longint im;
        nWr = wrQ.size() - wb;
        checkVal("n_writes", longint'(nWr), longint'(c_n));
        for (int i = 0; i < nWr && i < c_n; i++) begin
            r  = wrQ[wb + i];
            re = longint'($signed(r.data[31:0]));
            im = longint'($signed(r.data[63:32]));
            checkVal($sformatf("wr_cyc[%0d]", i), longint'(r.cyc), longint'(sc + 4 + i));
            checkVal($sformatf("wr_addr[%0d]", i), longint'(r.addr), longint'(i));
            checkVal($sformatf("wr_busy[%0d]", i), longint'(r.busy), longint'(1));
            checkVal($sformatf("re[%0d]", i), re, modelRe(i), longint'(1));
            checkVal($sformatf("im[%0d]", i), im, modelIm(i), longint'(1));
            if ((i % 16) == 0) begin
                checkVal($sformatf("key_word[%0d]", i), longint'(r.data),
                         longint'(c_keyWord[i / 16]));
            end
            if (i > c_n / 2) begin
                checkVal($sformatf("re_neg[%0d]", i), longint'(re < 0), longint'(1));
            end
        end
        nDn = doneCyc.size() - db;
        checkVal("n_done", longint'(nDn), longint'(1));
        if (nDn > 0) begin
            checkVal("done_cyc", longint'(doneCyc[db]), longint'(sc + 4 + c_n));
            checkVal("busy_at_done", longint'(doneBusy[db]), longint'(0));
        end
    endtask

    // One fill; extraMask[off] re-asserts start in cycle sc+off (all ignored).
    task automatic runFill(input logic [68:0] extraMask);
        int sc;
        int wb;
        int db;
        repeat ($urandom_range(4, 0)) @(posedge clk);
        wb = wrQ.size();
        db = doneCyc.size();
        @(posedge clk);
        #1 start = 1'b1;
        sc = cycleCnt;
        for (int off = 1; off <= 68; off++) begin
            @(posedge clk);
            #1 start = extraMask[off];
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (12) @(posedge clk);
        verifyFill(sc, wb, db);
    endtask

    // Start a fill, then pull nGrst low mid-cycle off cycles later.
    task automatic abortFill(input int off);
        int sc;
        int wb;
        int db;
        int wa;
        wb = wrQ.size();
        db = doneCyc.size();
        @(posedge clk);
        #1 start = 1'b1;
        sc = cycleCnt;
        @(posedge clk);
        #1 start = 1'b0;
        for (int j = 2; j <= off; j++) @(posedge clk);
        #2;
        checkVal("wen_pre_abort", longint'(wEn), longint'(off >= 4 && off <= 67));
        #1 nGrst = 1'b0;
        #1;
        checkVal("wen_in_abort", longint'(wEn), longint'(0));
        checkVal("busy_in_abort", longint'(busy), longint'(0));
        checkVal("done_in_abort", longint'(done), longint'(0));
        checkVal("addr_in_abort", longint'(wAddr), longint'(0));
        checkVal("data_in_abort", longint'(wD), longint'(0));
        checkVal("wr_before_abort", longint'(wrQ.size() - wb),
                 longint'((off >= 4) ? off - 4 : 0));
        wa = wrQ.size();
        repeat (2) @(posedge clk);
        #1 nGrst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkVal("wr_after_abort", longint'(wrQ.size() - wa), longint'(0));
        checkVal("done_after_abort", longint'(doneCyc.size() - db), longint'(0));
        checkVal("busy_after_abort", longint'(busy), longint'(0));
        if (sc < 0) nFails++;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin : stimulus
        logic [68:0] mask;
        nGrst = 1'b1;
        start = 1'b0;
        #2 nGrst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_ctrl", longint'({busy, done, wEn}), longint'(0));
        checkVal("rst_addr", longint'(wAddr), longint'(0));
        checkVal("rst_data", longint'(wD), longint'(0));
        @(posedge clk);
        #1 nGrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkVal("idle_ctrl", longint'({busy, done, wEn}), longint'(0));
            checkVal("idle_addr", longint'(wAddr), longint'(0));
            checkVal("idle_data", longint'(wD), longint'(0));
        end

        runFill('0);

        mask     = '0;
        mask[5]  = 1'b1;
        mask[63] = 1'b1;
        mask[68] = 1'b1;
        runFill(mask);

        for (int t = 0; t < 2; t++) begin
            mask = 69'({$urandom(), $urandom(), $urandom()});
            runFill(mask);
        end

        abortFill(20);
        runFill('0);

        abortFill(int'($urandom_range(60, 6)));
        mask = 69'({$urandom(), $urandom(), $urandom()});
        runFill(mask);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
